// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-sequencer signal bundle between the pipeline datapath (master) and the controller (slave)
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_dest_reg;
    logic [1:0]       ex_mem_read;
    logic             ex_reg_write_enable;
    logic             ex_pc_sel;
    logic             ex_mdu_start;
    logic             mdu_done;
    logic             pc_write_en;
    logic             if_id_write_en;
    logic             id_ex_write_en;
    logic             ex_ma_write_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_ma_bubble;
    logic [CNT_W-1:0] stall_count;
    logic             mdu_timeout;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_dest_reg, ex_mem_read,
               ex_reg_write_enable, ex_pc_sel, ex_mdu_start, mdu_done,
        input  pc_write_en, if_id_write_en, id_ex_write_en, ex_ma_write_en,
               if_id_flush, id_ex_flush, ex_ma_bubble, stall_count, mdu_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_dest_reg, ex_mem_read,
               ex_reg_write_enable, ex_pc_sel, ex_mdu_start, mdu_done,
        output pc_write_en, if_id_write_en, id_ex_write_en, ex_ma_write_en,
               if_id_flush, id_ex_flush, ex_ma_bubble, stall_count, mdu_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, taken branches and multi-cycle MDU ops
module pipeline_hazard_ctrl #(
    parameter int MDU_TIMEOUT_CYCLES = 40,
    parameter int CNT_W              = 16
) (
    input logic                  i_clk,
    input logic                  i_rst,
    pipeline_hazard_ctrl_if.slave io_hz
);
    localparam int WW = $clog2(MDU_TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] LAST = WW'(MDU_TIMEOUT_CYCLES - 1);

    typedef enum logic {RUN, MDU_WAIT} state_t;

    state_t           r_state;
    logic [WW-1:0]    r_wait_cnt;
    logic [CNT_W-1:0] r_stall_count;
    logic             r_mdu_timeout;
    logic             w_load_use;
    logic             w_mdu_enter;
    logic             w_release;
    logic             w_hold;
    logic             w_lu;
    logic             w_br;
    logic             w_pc_we;

    assign w_load_use = (io_hz.ex_mem_read != 2'd0) && io_hz.ex_reg_write_enable && (io_hz.ex_dest_reg != 5'd0) &&
                        ((io_hz.id_uses_rs1 && io_hz.id_rs1 == io_hz.ex_dest_reg) ||
                         (io_hz.id_uses_rs2 && io_hz.id_rs2 == io_hz.ex_dest_reg));
    assign w_mdu_enter = r_state == RUN && !io_hz.ex_pc_sel && io_hz.ex_mdu_start && !io_hz.mdu_done;
    assign w_release   = r_state == MDU_WAIT && (io_hz.mdu_done || r_wait_cnt >= LAST);

    // Reset is asynchronous, so the overrides are gated with i_rst to force defaults immediately
    assign w_hold  = !i_rst && (w_mdu_enter || (r_state == MDU_WAIT && !w_release));
    assign w_br    = !i_rst && r_state == RUN && io_hz.ex_pc_sel;
    assign w_lu    = !i_rst && r_state == RUN && !io_hz.ex_pc_sel && !io_hz.ex_mdu_start && w_load_use;
    assign w_pc_we = !(w_hold || w_lu);

    assign io_hz.pc_write_en    = w_pc_we;
    assign io_hz.if_id_write_en = w_pc_we;
    assign io_hz.id_ex_write_en = !w_hold;
    assign io_hz.ex_ma_write_en = !w_hold;
    assign io_hz.if_id_flush    = w_br;
    assign io_hz.id_ex_flush    = w_br || w_lu;
    assign io_hz.ex_ma_bubble   = w_hold;
    assign io_hz.stall_count    = r_stall_count;
    assign io_hz.mdu_timeout    = r_mdu_timeout;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_stall_count <= '0;
            r_mdu_timeout <= 1'b0;
        end else begin
            if (r_state == RUN) begin
                r_state    <= w_mdu_enter ? MDU_WAIT : RUN;
                r_wait_cnt <= w_mdu_enter ? WW'(1) : '0;
            end else begin
                r_state    <= w_release ? RUN : MDU_WAIT;
                r_wait_cnt <= w_release ? '0 : r_wait_cnt + WW'(1);
                if (w_release && !io_hz.mdu_done)
                    r_mdu_timeout <= 1'b1;
            end
            if (!w_pc_we && r_stall_count != '1)
                r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of load-use, branch, MDU wait/timeout, async reset and counter saturation
module tb_pipeline_hazard_ctrl;
    // control vector order: pc_we, if_id_we, id_ex_we, ex_ma_we, if_id_flush, id_ex_flush, ex_ma_bubble
    localparam logic [6:0] DEF  = 7'b1111000;
    localparam logic [6:0] LU   = 7'b0011010;
    localparam logic [6:0] BR   = 7'b1111110;
    localparam logic [6:0] HOLD = 7'b0000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) hz ();
    pipeline_hazard_ctrl_if #(.CNT_W(3))  hz3 ();

    pipeline_hazard_ctrl #(.MDU_TIMEOUT_CYCLES(40), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .io_hz(hz.slave)
    );
    pipeline_hazard_ctrl #(.MDU_TIMEOUT_CYCLES(40), .CNT_W(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .io_hz(hz3.slave)
    );

    function automatic logic [6:0] ctl();
        return {hz.pc_write_en, hz.if_id_write_en, hz.id_ex_write_en, hz.ex_ma_write_en,
                hz.if_id_flush, hz.id_ex_flush, hz.ex_ma_bubble};
    endfunction

    task automatic chk_ctl(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = ctl();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: ctl got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_cnt(input string name, input int exp);
        checks++;
        if (hz.stall_count !== 16'(exp)) begin
            errors++;
            $display("FAIL %s: stall_count got %0d expected %0d", name, hz.stall_count, exp);
        end
    endtask

    task automatic chk_to(input string name, input logic exp);
        checks++;
        if (hz.mdu_timeout !== exp) begin
            errors++;
            $display("FAIL %s: mdu_timeout got %b expected %b", name, hz.mdu_timeout, exp);
        end
    endtask

    task automatic idle();
        hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_uses_rs1 = 1'b0; hz.id_uses_rs2 = 1'b0;
        hz.ex_dest_reg = 5'd0; hz.ex_mem_read = 2'd0; hz.ex_reg_write_enable = 1'b0;
        hz.ex_pc_sel = 1'b0; hz.ex_mdu_start = 1'b0; hz.mdu_done = 1'b0;
        hz3.id_rs1 = 5'd0; hz3.id_rs2 = 5'd0; hz3.id_uses_rs1 = 1'b0; hz3.id_uses_rs2 = 1'b0;
        hz3.ex_dest_reg = 5'd0; hz3.ex_mem_read = 2'd0; hz3.ex_reg_write_enable = 1'b0;
        hz3.ex_pc_sel = 1'b0; hz3.ex_mdu_start = 1'b0; hz3.mdu_done = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] dest);
        hz.ex_mem_read = 2'd2; hz.ex_reg_write_enable = 1'b1; hz.ex_dest_reg = dest;
        hz.id_rs1 = 5'd3; hz.id_uses_rs1 = 1'b1; hz.id_rs2 = 5'd5; hz.id_uses_rs2 = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        set_lu(5'd5);
        #2;
        chk_ctl("reset_forces_defaults", DEF);
        chk_cnt("reset_count", 0);
        chk_to("reset_timeout", 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1 chk_ctl("idle_defaults", DEF);
    endtask

    task automatic test_load_use();
        @(negedge clk);
        set_lu(5'd5);
        #1 chk_ctl("load_use_stall", LU);
        @(negedge clk);
        idle();
        #1 chk_cnt("load_use_count", 1);
        chk_ctl("load_use_clears", DEF);
        set_lu(5'd0);
        #1 chk_ctl("load_use_x0_no_stall", DEF);
        hz.ex_mem_read = 2'd0;
        hz.ex_dest_reg = 5'd5;
        #1 chk_ctl("no_load_no_stall", DEF);
        @(negedge clk);
        idle();
        #1 chk_cnt("x0_count_unchanged", 1);
    endtask

    task automatic test_branch();
        set_lu(5'd5);
        hz.ex_pc_sel = 1'b1;
        #1 chk_ctl("branch_over_load_use", BR);
        @(negedge clk);
        idle();
        #1 chk_cnt("branch_no_stall_count", 1);
    endtask

    task automatic test_mdu_div();
        hz.ex_mdu_start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            hz.ex_pc_sel = (k == 3);
            #1 chk_ctl($sformatf("div_hold_%0d", k), HOLD);
            @(negedge clk);
        end
        hz.ex_pc_sel = 1'b0;
        hz.mdu_done = 1'b1;
        #1 chk_ctl("div_done_release", DEF);
        @(negedge clk);
        idle();
        set_lu(5'd5);
        #1 chk_ctl("div_back_in_run", LU);
        @(negedge clk);
        idle();
        #1 chk_cnt("div_count", 6);
    endtask

    task automatic test_back_to_back();
        hz.ex_mdu_start = 1'b1;
        #1 chk_ctl("b2b_first_hold", HOLD);
        @(negedge clk);
        hz.mdu_done = 1'b1;
        #1 chk_ctl("b2b_first_done", DEF);
        @(negedge clk);
        hz.mdu_done = 1'b0;
        #1 chk_ctl("b2b_second_hold", HOLD);
        @(negedge clk);
        hz.mdu_done = 1'b1;
        #1 chk_ctl("b2b_second_done", DEF);
        hz.mdu_done = 1'b0;
        hz.ex_mdu_start = 1'b1;
        hz.mdu_done = 1'b1;
        @(negedge clk);
        #1 chk_ctl("single_cycle_mdu_no_stall", DEF);
        @(negedge clk);
        idle();
        #1 chk_cnt("b2b_count", 8);
        chk_to("no_timeout_yet", 1'b0);
    endtask

    task automatic test_timeout();
        int bad = 0;
        hz.ex_mdu_start = 1'b1;
        for (int k = 1; k <= 39; k++) begin
            #1 if (ctl() !== HOLD) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_hold_cycles: %0d of 39 cycles not held, expected 0", bad);
        end
        chk_to("timeout_not_before_release", 1'b0);
        #1 chk_ctl("timeout_release_40th", DEF);
        @(negedge clk);
        idle();
        #1 chk_to("timeout_set", 1'b1);
        chk_cnt("timeout_count", 47);
        repeat (3) @(negedge clk);
        #1 chk_to("timeout_sticky", 1'b1);
    endtask

    task automatic test_async_reset();
        hz.ex_mdu_start = 1'b1;
        @(negedge clk);
        #1 chk_ctl("pre_reset_wait_hold", HOLD);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_ctl("async_reset_defaults", DEF);
        chk_cnt("async_reset_count", 0);
        chk_to("async_reset_timeout", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        set_lu(5'd5);
        #1 chk_ctl("after_reset_in_run", LU);
        @(negedge clk);
        idle();
        #1 chk_cnt("after_reset_count", 1);
    endtask

    task automatic test_saturation();
        for (int n = 1; n <= 9; n++) begin
            hz3.ex_mem_read = 2'd1; hz3.ex_reg_write_enable = 1'b1; hz3.ex_dest_reg = 5'd7;
            hz3.id_rs1 = 5'd7; hz3.id_uses_rs1 = 1'b1;
            @(negedge clk);
            #1 checks++;
            if (hz3.stall_count !== 3'((n > 7) ? 7 : n)) begin
                errors++;
                $display("FAIL saturate_%0d: stall_count got %0d expected %0d", n, hz3.stall_count, (n > 7) ? 7 : n);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mdu_div();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the RV32IM five-stage pipeline. Drives the write-enable and flush/bubble controls of the PC, IF_ID, ID_EX and EX_MA pipeline registers. Resolves three hazards: load-use data hazards, taken branches/jumps resolved in EX, and multi-cycle M-extension (MUL/DIV/REM) operations that hold EX until the iterative unit finishes. Also provides a saturating stall-cycle counter and a sticky MDU timeout flag for debug.

## Interface
Parameters:
- MDU_TIMEOUT_CYCLES, 40, maximum MDU_WAIT cycles before a forced release (≥2)
- CNT_W, 16, width of STALL_COUNT

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- ID_RS1, ID_RS2  in  5 each  source register addresses of the instruction in ID
- ID_USES_RS1, ID_USES_RS2  in  1 each  instruction in ID actually reads that source
- EX_DEST_REG  in  5  destination register of the instruction in EX
- EX_MEM_READ  in  2  memory-read code of the instruction in EX; non-zero means a load
- EX_REG_WRITE_ENABLE  in  1  instruction in EX writes the register file
- EX_PC_SEL  in  1  branch/jump taken, resolved in EX
- EX_MDU_START  in  1  level; a multi-cycle M-extension op occupies EX
- MDU_DONE  in  1  MDU result valid this cycle
- PC_WRITE_EN  out  1  PC register update enable
- IF_ID_WRITE_EN  out  1  IF_ID register load enable
- ID_EX_WRITE_EN  out  1  ID_EX register load enable
- EX_MA_WRITE_EN  out  1  EX_MA register load enable
- IF_ID_FLUSH  out  1  load a NOP into IF_ID
- ID_EX_FLUSH  out  1  load a bubble into ID_EX (control fields zeroed)
- EX_MA_BUBBLE  out  1  load a bubble into EX_MA
- STALL_COUNT  out  CNT_W  saturating count of cycles with PC_WRITE_EN=0
- MDU_TIMEOUT  out  1  sticky; set on forced MDU release

## Operation
- FSM states: RUN, MDU_WAIT. Reset state: RUN.
- Default outputs: all *_WRITE_EN=1, all flush/bubble=0.
- load_use = EX_MEM_READ!=0 & EX_REG_WRITE_ENABLE & EX_DEST_REG!=0 & ((ID_USES_RS1 & ID_RS1==EX_DEST_REG) | (ID_USES_RS2 & ID_RS2==EX_DEST_REG)).
- RUN priority, highest first:
  - EX_PC_SEL=1: IF_ID_FLUSH=1 and ID_EX_FLUSH=1; PC loads the target (PC_WRITE_EN=1). Overrides load_use and EX_MDU_START. Stay in RUN.
  - EX_MDU_START=1 & MDU_DONE=0: PC, IF_ID, ID_EX and EX_MA write enables =0; EX_MA_BUBBLE=1. Next state MDU_WAIT, wait_cnt←1.
  - EX_MDU_START=1 & MDU_DONE=1: no stall (single-cycle result, e.g. divide-by-zero).
  - load_use: PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EX_FLUSH=1. No state change; the hazard clears when the load reaches MA.
- MDU_WAIT:
  - MDU_DONE=0 and wait_cnt<MDU_TIMEOUT_CYCLES-1: same hold outputs as the MDU entry cycle; wait_cnt+1.
  - MDU_DONE=1: default outputs (EX result captured into EX_MA); next state RUN.
  - MDU_DONE=0 and wait_cnt==MDU_TIMEOUT_CYCLES-1: default outputs; MDU_TIMEOUT←1; next state RUN.
  - EX_PC_SEL, EX_MDU_START and load_use are ignored.
- wait_cnt width: $clog2(MDU_TIMEOUT_CYCLES+1). Cleared in RUN.
- STALL_COUNT: +1 on every edge where PC_WRITE_EN=0. Holds at 2^CNT_W-1 and does not wrap.

## Timing
- Control outputs are combinational from state and current inputs, valid in the same cycle. The pipeline registers act on them at the next rising CLK.
- State, wait_cnt, STALL_COUNT and MDU_TIMEOUT are registered.
- Reset values: state=RUN, wait_cnt=0, STALL_COUNT=0, MDU_TIMEOUT=0.
- While RESET=1, outputs are forced to defaults: enables=1, flushes/bubble=0.
- RESET asserted during MDU_WAIT returns the FSM to RUN immediately, without waiting for a clock.
- Load-use costs exactly 1 stall cycle.
- Taken branch costs 2 flushed slots; both flushes are asserted in a single cycle.
- MDU op finishing on the k-th cycle in EX (k≥2) costs k-1 stall cycles. Back-to-back MDU ops re-enter MDU_WAIT the cycle after RUN is re-entered.
- Forced timeout release occurs after exactly MDU_TIMEOUT_CYCLES cycles in EX.

## Test plan
- Load-use: EX lw with EX_DEST_REG=5, ID_RS2=5, ID_USES_RS2=1 -> one cycle of PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EX_FLUSH=1. STALL_COUNT goes 0→1. Same case with EX_DEST_REG=0 -> no stall.
- Branch over load-use: EX_PC_SEL=1 while load_use conditions are true -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_WRITE_EN=1, STALL_COUNT unchanged.
- DIV with MDU_DONE asserted on the 5th cycle in EX -> 4 cycles with all write enables=0 and EX_MA_BUBBLE=1, then defaults. STALL_COUNT=4. Back in RUN.
- MDU_DONE never asserted, MDU_TIMEOUT_CYCLES=40 -> 39 hold cycles, release on the 40th, MDU_TIMEOUT=1 and held until reset.
- RESET pulsed asynchronously mid MDU_WAIT (between edges) -> outputs return to defaults immediately; STALL_COUNT=0, MDU_TIMEOUT=0, state RUN.
- CNT_W=3 with 9 consecutive load-use stalls -> STALL_COUNT saturates at 7.
